// File: rtl/carry_save_accumulator.sv
// Two-stage accumulator for redundant (sum/carry) partial results: stage A resolves the
// carry-propagate add, stage B accumulates per group. Define CSA_ACC_SAT_EN for saturating accumulation.
module carry_save_accumulator #(
  parameter int IN_SIZE  = 16,
  parameter int ACC_SIZE = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [IN_SIZE-1:0]  sum_i,
  input  logic [IN_SIZE-1:0]  carry_i,
  input  logic                first_i,
  input  logic                last_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [ACC_SIZE-1:0] acc_o,
  output logic                overflow_o
);

  logic                stall, accept;
  logic [ACC_SIZE-1:0] sum_ext, carry_ext, v_in;
  logic [ACC_SIZE-1:0] acc_add, acc_upd;
  logic                sat_hit;

  logic                a_vld_q, a_vld_d;
  logic                a_first_q, a_first_d;
  logic                a_last_q, a_last_d;
  logic [ACC_SIZE-1:0] a_v_q, a_v_d;
  logic [ACC_SIZE-1:0] acc_q, acc_d;
  logic                grp_ovf_q, grp_ovf_d;
  logic [ACC_SIZE-1:0] res_q, res_d;
  logic                res_ovf_q, res_ovf_d;
  logic                res_vld_q, res_vld_d;

  assign stall   = res_vld_q && !ready_i;
  assign ready_o = !stall;
  assign accept  = valid_i && ready_o;

  assign sum_ext   = ACC_SIZE'($signed(sum_i));
  assign carry_ext = ACC_SIZE'($signed(carry_i));
  assign v_in      = sum_ext + carry_ext;

  assign acc_add = acc_q + a_v_q;

`ifdef CSA_ACC_SAT_EN
  // Signed overflow: both operands share a sign the wrapped sum does not.
  logic pos_ovf, neg_ovf;
  assign pos_ovf = !acc_q[ACC_SIZE-1] && !a_v_q[ACC_SIZE-1] &&  acc_add[ACC_SIZE-1];
  assign neg_ovf =  acc_q[ACC_SIZE-1] &&  a_v_q[ACC_SIZE-1] && !acc_add[ACC_SIZE-1];
  assign sat_hit = pos_ovf || neg_ovf;
  always_comb begin
    acc_upd = acc_add;
    if (pos_ovf) acc_upd = {1'b0, {(ACC_SIZE-1){1'b1}}};
    if (neg_ovf) acc_upd = {1'b1, {(ACC_SIZE-1){1'b0}}};
  end
`else
  assign sat_hit = 1'b0;
  assign acc_upd = acc_add;
`endif

  always_comb begin
    a_vld_d   = a_vld_q;
    a_first_d = a_first_q;
    a_last_d  = a_last_q;
    a_v_d     = a_v_q;
    acc_d     = acc_q;
    grp_ovf_d = grp_ovf_q;
    res_d     = res_q;
    res_ovf_d = res_ovf_q;
    res_vld_d = res_vld_q;
    if (!stall) begin
      a_vld_d   = accept;
      a_first_d = accept && first_i;
      a_last_d  = accept && last_i;
      if (accept) a_v_d = v_in;
      if (res_vld_q && ready_i) res_vld_d = 1'b0;
      if (a_vld_q) begin
        acc_d     = a_first_q ? a_v_q : acc_upd;
        grp_ovf_d = a_first_q ? 1'b0 : (grp_ovf_q || sat_hit);
        // A load on the drain edge keeps valid high with the new result.
        if (a_last_q) begin
          res_d     = acc_d;
          res_ovf_d = grp_ovf_d;
          res_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_vld_q   <= 1'b0;
      a_first_q <= 1'b0;
      a_last_q  <= 1'b0;
      a_v_q     <= '0;
      acc_q     <= '0;
      grp_ovf_q <= 1'b0;
      res_q     <= '0;
      res_ovf_q <= 1'b0;
      res_vld_q <= 1'b0;
    end else begin
      a_vld_q   <= a_vld_d;
      a_first_q <= a_first_d;
      a_last_q  <= a_last_d;
      a_v_q     <= a_v_d;
      acc_q     <= acc_d;
      grp_ovf_q <= grp_ovf_d;
      res_q     <= res_d;
      res_ovf_q <= res_ovf_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign valid_o    = res_vld_q;
  assign acc_o      = res_q;
  assign overflow_o = res_ovf_q;

endmodule

// File: tb/tb_carry_save_accumulator.sv
// Directed-vector bench: a default 16/32 instance and a 16/16 instance for the
// saturation/wrap boundary.
module tb_carry_save_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, first_i, last_i, ready_i;
  logic [15:0] sum_i, carry_i;
  logic        ready_o, valid_o, overflow_o;
  logic [31:0] acc_o;

  logic        valid16, first16, last16, rdy_in16;
  logic [15:0] sum16, carry16;
  logic        ready16, vout16, ovf16;
  logic [15:0] acc16;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  carry_save_accumulator #(.IN_SIZE(16), .ACC_SIZE(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .sum_i(sum_i), .carry_i(carry_i), .first_i(first_i), .last_i(last_i),
    .valid_o(valid_o), .ready_i(ready_i), .acc_o(acc_o), .overflow_o(overflow_o)
  );

  carry_save_accumulator #(.IN_SIZE(16), .ACC_SIZE(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid16), .ready_o(ready16),
    .sum_i(sum16), .carry_i(carry16), .first_i(first16), .last_i(last16),
    .valid_o(vout16), .ready_i(rdy_in16), .acc_o(acc16), .overflow_o(ovf16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic f, input logic l, input logic [15:0] s, input logic [15:0] c);
    valid_i = 1'b1; first_i = f; last_i = l; sum_i = s; carry_i = c;
  endtask

  task automatic beat(input logic f, input logic l, input logic [15:0] s, input logic [15:0] c);
    drive(f, l, s, c);
    tick();
    valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic beat16(input logic f, input logic l, input logic [15:0] s);
    valid16 = 1'b1; first16 = f; last16 = l; sum16 = s; carry16 = 16'h0000;
    tick();
    valid16 = 1'b0; first16 = 1'b0; last16 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0; ready_i = 1'b1;
    sum_i = '0; carry_i = '0;
    valid16 = 1'b0; first16 = 1'b0; last16 = 1'b0; rdy_in16 = 1'b1;
    sum16 = '0; carry16 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", valid_o, 0);
    chk("rst_acc", acc_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_ready", ready_o, 1);

    // single beat 5 + 6
    beat(1, 1, 16'h0005, 16'h0006);
    chk("single_lat1", valid_o, 0);
    tick();
    chk("single_valid", valid_o, 1);
    chk("single_acc", acc_o, 32'd11);
    chk("single_ovf", overflow_o, 0);
    tick();
    chk("single_drain", valid_o, 0);

    // four beats of (-3)+4 = 1
    beat(1, 0, 16'hFFFD, 16'h0004);
    beat(0, 0, 16'hFFFD, 16'h0004);
    beat(0, 0, 16'hFFFD, 16'h0004);
    beat(0, 1, 16'hFFFD, 16'h0004);
    chk("grp4_nopulse", valid_o, 0);
    tick();
    chk("grp4_valid", valid_o, 1);
    chk("grp4_acc", acc_o, 32'd4);
    tick();
    chk("grp4_onepulse", valid_o, 0);

    // negative single, then continue without first onto retained value
    beat(1, 1, 16'hFFF6, 16'h0002);
    tick();
    chk("neg_acc", acc_o, 32'hFFFF_FFF8);
    beat(0, 1, 16'h0003, 16'h0000);
    tick();
    chk("retain_valid", valid_o, 1);
    chk("retain_acc", acc_o, 32'hFFFF_FFFB);

    // bubbles inside a group
    beat(1, 0, 16'd10, 16'h0000);
    tick(); tick();
    beat(0, 1, 16'd5, 16'h0000);
    tick();
    chk("bubble_acc", acc_o, 32'd15);
    tick();

    // back-pressure with the input held
    ready_i = 1'b0;
    beat(1, 1, 16'h0000, 16'h0002);
    drive(1, 0, 16'd20, 16'h0000);
    tick();
    chk("stall_valid", valid_o, 1);
    drive(0, 1, 16'd30, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      chk("stall_ready", ready_o, 0);
      chk("stall_acc", acc_o, 32'd2);
      tick();
    end
    ready_i = 1'b1;
    #1;
    chk("unstall_ready", ready_o, 1);
    tick();
    valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
    chk("unstall_drain", valid_o, 0);
    tick();
    chk("stall_res_valid", valid_o, 1);
    chk("stall_res_acc", acc_o, 32'd50);
    tick();
    chk("stall_res_drain", valid_o, 0);

    // drain and load on the same edge
    beat(1, 1, 16'h0001, 16'h0000);
    beat(1, 1, 16'h0002, 16'h0000);
    chk("b2b_first", acc_o, 32'd1);
    tick();
    chk("b2b_valid", valid_o, 1);
    chk("b2b_second", acc_o, 32'd2);
    tick();
    chk("b2b_nodup", valid_o, 0);

    // reset mid-group
    beat(1, 0, 16'd100, 16'h0000);
    beat(0, 0, 16'd100, 16'h0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_ready", ready_o, 1);
    beat(1, 1, 16'h0007, 16'h0000);
    chk("midrst_nores", valid_o, 0);
    tick();
    chk("midrst_acc", acc_o, 32'd7);
    tick();
    chk("midrst_nodup", valid_o, 0);

    // accumulate onto zero after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    beat(0, 1, 16'h0009, 16'h0000);
    tick();
    chk("postrst_acc", acc_o, 32'd9);
    tick();

    // 16-bit accumulator boundary: 3 x 0x4000
    beat16(1, 0, 16'h4000);
    beat16(0, 0, 16'h4000);
    beat16(0, 1, 16'h4000);
    tick();
    chk("sat16_valid", vout16, 1);
`ifdef CSA_ACC_SAT_EN
    chk("sat16_acc", acc16, 32'h7FFF);
    chk("sat16_ovf", ovf16, 1);
`else
    chk("wrap16_acc", acc16, 32'hC000);
    chk("wrap16_ovf", ovf16, 0);
`endif
    beat16(1, 1, 16'h0001);
    tick();
    chk("clr16_acc", acc16, 32'h0001);
    chk("clr16_ovf", ovf16, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/carry_save_accumulator.md
CARRY_SAVE_ACCUMULATOR -- requirements
Module: carry_save_accumulator

Interface
REQ-001 SHALL have parameter IN_SIZE, default 16: width of the redundant sum/carry input vectors.
REQ-002 SHALL have parameter ACC_SIZE, default 32: accumulator and result width; ACC_SIZE >= IN_SIZE.
REQ-003 SHALL have clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have valid_i  input  1  input beat valid.
REQ-006 SHALL have ready_o  output  1  block can accept a beat this cycle.
REQ-007 SHALL have sum_i  input  IN_SIZE  two's-complement sum vector from the 4:2 compressor stage.
REQ-008 SHALL have carry_i  input  IN_SIZE  two's-complement carry vector, already weight-aligned (bit 0 is zero upstream).
REQ-009 SHALL have first_i  input  1  beat starts a new accumulation group.
REQ-010 SHALL have last_i  input  1  beat closes the current group.
REQ-011 SHALL have valid_o  output  1  result valid.
REQ-012 SHALL have ready_i  input  1  downstream accepts the result.
REQ-013 SHALL have acc_o  output  ACC_SIZE  signed accumulated result.
REQ-014 SHALL have overflow_o  output  1  the group in acc_o saturated; qualified by valid_o.

Function
REQ-015 A beat SHALL be accepted exactly when valid_i && ready_o; first_i/last_i/sum_i/carry_i are ignored otherwise.
REQ-016 stall = valid_o && !ready_i; ready_o SHALL equal !stall (combinational); all pipeline registers SHALL hold while stall is high.
REQ-017 Stage A SHALL register v = sext(sum_i) + sext(carry_i) to ACC_SIZE bits (carry-propagate add, modulo 2^ACC_SIZE) with valid, first and last flags.
REQ-018 Stage B SHALL update acc <= v if the stage-A first flag is set, else acc <= acc + v (wrap or saturate per REQ-027/028).
REQ-019 When a stage-B update carries the last flag, the updated value SHALL be loaded into acc_o with valid_o = 1 on the same edge.
REQ-020 Latency: last beat accepted on edge n -> valid_o high after edge n+2; throughput one beat per cycle without stall.
REQ-021 valid_o and acc_o SHALL remain stable until the edge where valid_o && ready_i; valid_o then clears unless a new last result loads that same edge, in which case valid_o stays 1 with the new acc_o.
REQ-022 first_i && last_i on the same beat SHALL produce acc_o = v.
REQ-023 A beat without first_i following reset or a previous last SHALL accumulate onto the current acc value (0 after reset, retained value otherwise).
REQ-024 Stage-A bubbles (no accepted beat) SHALL leave acc unchanged.

Reset
REQ-025 rst_i high at an edge SHALL clear acc, acc_o, overflow_o, valid_o, all stage valid/flag registers to 0; ready_o is 1 the cycle after.
REQ-026 Reset mid-group SHALL discard all in-flight beats and partial sums; no result is emitted for that group.

Configuration
REQ-027 With CSA_ACC_SAT_EN defined, stage-B addition SHALL saturate to [-2^(ACC_SIZE-1), 2^(ACC_SIZE-1)-1]; a sticky group overflow bit SHALL be set on any saturating update, cleared by a first beat, and copied into overflow_o with the result.
REQ-028 Without CSA_ACC_SAT_EN, stage-B addition SHALL wrap modulo 2^ACC_SIZE and overflow_o SHALL be constant 0.

Verification
REQ-029 Single beat first+last, sum_i=16'h0005, carry_i=16'h0006 -> valid_o two cycles later, acc_o=32'd11.
REQ-030 Group of 4 beats back-to-back, each sum=-3 (16'hFFFD), carry=16'h0004 -> acc_o=32'd4, one valid_o pulse.
REQ-031 ready_i low 5 cycles while result pending, valid_i held high -> ready_o low, acc_o stable, no beat lost; final results match golden model.
REQ-032 CSA_ACC_SAT_EN, ACC_SIZE=16, beats of +16'h4000 x3 -> acc_o=16'h7FFF, overflow_o=1; without macro acc_o=16'hC000, overflow_o=0.
REQ-033 rst_i pulsed after 2 beats of a group, then new group first+last v=7 -> only acc_o=7 emitted.
REQ-034 Result drained (ready_i=1) on the same edge a new last result loads -> valid_o stays 1, acc_o switches to new value, no duplicate.
